// File: rtl/hex_inverter_prober.sv
// Hex inverter prober: drives every WIDTH-bit pattern in ascending order onto a
// gate package, waits SETTLE cycles, and checks the response against the
// expected polarity. It counts the mismatching patterns and records the first
// failing stimulus.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        run request, sampled only in IDLE
//   a_out        registered stimulus to the gate inputs
//   y_in         gate outputs, sampled only in SAMPLE
//   busy         high from the cycle after start through the last SAMPLE cycle
//   done         one-cycle end-of-run pulse
//   pass         run completed with no mismatches, held until the next start
//   err_count    number of mismatching patterns in the current or last run
//   fail_valid   at least one mismatch recorded
//   fail_pattern stimulus of the first mismatch
module hex_inverter_prober #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned SETTLE = 2,
    parameter bit          INVERT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_pattern
);

    localparam int unsigned CntW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SettleLast = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StSample,
        StDone
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  pat_cnt;
    logic [CntW-1:0]   wait_cnt;
    logic [WIDTH-1:0]  expected;
    logic              mismatch;

    always_comb begin
        expected = INVERT ? ~a_out : a_out;
        mismatch = (y_in != expected);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            pat_cnt      <= '0;
            wait_cnt     <= '0;
            a_out        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_pattern <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        pat_cnt      <= '0;
                        err_count    <= '0;
                        pass         <= 1'b0;
                        fail_valid   <= 1'b0;
                        fail_pattern <= '0;
                        busy         <= 1'b1;
                        state        <= StDrive;
                    end
                end
                StDrive: begin
                    a_out    <= pat_cnt;
                    wait_cnt <= '0;
                    state    <= (SETTLE > 0) ? StWait : StSample;
                end
                StWait: begin
                    if (wait_cnt == CntW'(SettleLast)) begin
                        state <= StSample;
                    end else begin
                        wait_cnt <= wait_cnt + CntW'(1);
                    end
                end
                StSample: begin
                    if (mismatch) begin
                        err_count <= err_count + {{WIDTH{1'b0}}, 1'b1};
                        if (!fail_valid) begin
                            fail_valid   <= 1'b1;
                            fail_pattern <= a_out;
                        end
                    end
                    if (a_out == {WIDTH{1'b1}}) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Fold in a mismatch found on this final pattern.
                        pass  <= !mismatch && (err_count == '0);
                        state <= StDone;
                    end else begin
                        pat_cnt <= pat_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
                        state   <= StDrive;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_inverter_prober.sv
// Directed bench for hex_inverter_prober: three instances cover the inverter
// (SETTLE=2), buffer (INVERT=0) and zero-settle configurations, with a small
// gate model selectable per run.
module tb_hex_inverter_prober;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] st;
    int         mode;
    int         sel;
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [5:0] a0, a1, a2, y0, y1, y2, fp0, fp1, fp2;
    logic [6:0] e0, e1, e2;
    logic       b0, b1, b2, d0, d1, d2, p0, p1, p2, v0, v1, v2;

    logic [5:0] s_a, s_fp;
    logic [6:0] s_err;
    logic       s_busy, s_done, s_pass, s_fv;

    always #5 clk = ~clk;

    // 0 ideal inverter, 1 y[3] stuck at 0, 2 buffer, 3 inverter faulty only on 3F.
    function automatic logic [5:0] model(input int m, input logic [5:0] a);
        logic [5:0] y;
        case (m)
            1:       y = ~a & 6'b110111;
            2:       y = a;
            3:       y = (a == 6'h3F) ? 6'h01 : ~a;
            default: y = ~a;
        endcase
        return y;
    endfunction

    assign y0 = model(mode, a0);
    assign y1 = model(mode, a1);
    assign y2 = model(mode, a2);

    hex_inverter_prober #(.WIDTH(6), .SETTLE(2), .INVERT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(st[0]), .a_out(a0), .y_in(y0), .busy(b0),
        .done(d0), .pass(p0), .err_count(e0), .fail_valid(v0), .fail_pattern(fp0)
    );

    hex_inverter_prober #(.WIDTH(6), .SETTLE(2), .INVERT(1'b0)) dut_buf (
        .clk(clk), .reset(reset), .start(st[1]), .a_out(a1), .y_in(y1), .busy(b1),
        .done(d1), .pass(p1), .err_count(e1), .fail_valid(v1), .fail_pattern(fp1)
    );

    hex_inverter_prober #(.WIDTH(6), .SETTLE(0), .INVERT(1'b1)) dut_s0 (
        .clk(clk), .reset(reset), .start(st[2]), .a_out(a2), .y_in(y2), .busy(b2),
        .done(d2), .pass(p2), .err_count(e2), .fail_valid(v2), .fail_pattern(fp2)
    );

    always_comb begin
        s_a = a0; s_fp = fp0; s_err = e0; s_busy = b0; s_done = d0; s_pass = p0; s_fv = v0;
        case (sel)
            1: begin
                s_a = a1; s_fp = fp1; s_err = e1; s_busy = b1; s_done = d1; s_pass = p1;
                s_fv = v1;
            end
            2: begin
                s_a = a2; s_fp = fp2; s_err = e2; s_busy = b2; s_done = d2; s_pass = p2;
                s_fv = v2;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Runs one test on instance sel; start is held for the whole run when hold is set.
    task automatic run(input bit hold, output int bcycles);
        bit got;
        st[sel] = 1'b1;
        @(negedge clk);
        check("clr_err", 32'(s_err), 0);
        check("clr_fv", 32'(s_fv), 0);
        check("clr_pass", 32'(s_pass), 0);
        if (!hold) st[sel] = 1'b0;
        bcycles = 0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (s_done) got = 1'b1;
            else begin
                if (s_busy) bcycles++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(got), 1);
        check("busy_at_done", 32'(s_busy), 0);
        @(negedge clk);
        if (hold) st[sel] = 1'b0;
        check("done_pulse", 32'(s_done), 0);
    endtask

    initial begin
        int bc;
        reset = 1'b1;
        st    = '0;
        mode  = 0;
        sel   = 0;
        #3;
        check("rst_a", 32'(s_a), 0);
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_pass", 32'(s_pass), 0);
        check("rst_err", 32'(s_err), 0);
        check("rst_fv", 32'(s_fv), 0);
        check("rst_fp", 32'(s_fp), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Ideal inverter.
        run(1'b0, bc);
        check("ideal_busy", bc, 256);
        check("ideal_pass", 32'(s_pass), 1);
        check("ideal_err", 32'(s_err), 0);
        check("ideal_fv", 32'(s_fv), 0);
        check("ideal_a_hold", 32'(s_a), 32'h3F);

        // y[3] stuck at 0.
        mode = 1;
        run(1'b0, bc);
        check("stuck_err", 32'(s_err), 32);
        check("stuck_fv", 32'(s_fv), 1);
        check("stuck_fp", 32'(s_fp), 0);
        check("stuck_pass", 32'(s_pass), 0);
        repeat (5) @(negedge clk);
        check("stuck_err_hold", 32'(s_err), 32);
        check("stuck_fv_hold", 32'(s_fv), 1);
        check("stuck_a_hold", 32'(s_a), 32'h3F);

        // Buffer against the inverter and buffer expectations.
        mode = 2;
        run(1'b0, bc);
        check("buf_inv_err", 32'(s_err), 64);
        check("buf_inv_fp", 32'(s_fp), 0);
        check("buf_inv_pass", 32'(s_pass), 0);
        sel = 1;
        run(1'b0, bc);
        check("buf_busy", bc, 256);
        check("buf_pass", 32'(s_pass), 1);
        check("buf_err", 32'(s_err), 0);

        // Reset 100 cycles into a failing run.
        sel  = 0;
        mode = 1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_rst_busy", 32'(s_busy), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(s_busy), 0);
        check("mid_rst_err", 32'(s_err), 0);
        check("mid_rst_fv", 32'(s_fv), 0);
        check("mid_rst_a", 32'(s_a), 0);
        check("mid_rst_done", 32'(s_done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_done", 32'(s_done), 0);
        check("post_rst_busy", 32'(s_busy), 0);
        run(1'b0, bc);
        check("post_rst_run", bc, 256);
        check("post_rst_errc", 32'(s_err), 32);

        // start held for the whole run, then a fresh pulsed run.
        run(1'b1, bc);
        check("hold_busy", bc, 256);
        check("hold_err", 32'(s_err), 32);
        repeat (3) @(negedge clk);
        check("hold_no_restart", 32'(s_busy), 0);
        mode = 0;
        run(1'b0, bc);
        check("rerun_pass", 32'(s_pass), 1);
        check("rerun_err", 32'(s_err), 0);

        // Zero settle time.
        sel = 2;
        run(1'b0, bc);
        check("s0_busy", bc, 128);
        check("s0_pass", 32'(s_pass), 1);
        mode = 3;
        run(1'b0, bc);
        check("s0_last_err", 32'(s_err), 1);
        check("s0_last_fp", 32'(s_fp), 32'h3F);
        check("s0_last_pass", 32'(s_pass), 0);
        check("s0_last_fv", 32'(s_fv), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
